// File: rtl/sar_logic.sv
// Successive-approximation controller: sample, per-bit settle/strobe/wait, MSB-first commit.
// Optional sticky overwrite flag on the result port when SAR_OVERRUN_EN is defined.
module sar_logic #(
    parameter int N             = 16,
    parameter int SAMPLE_CYCLES = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    output logic         busy,
    output logic         samp,
    output logic [N-1:0] cap_botplate_m,
    output logic [N-1:0] cap_botplate_d,
    output logic         comp_clk,
    input  logic         comp_valid,
    input  logic         comp_out,
    output logic [N-1:0] dout,
    output logic         dout_valid,
    input  logic         dout_ready
`ifdef SAR_OVERRUN_EN
   ,output logic         overrun
`endif
);

    localparam int KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [2:0] {IDLE, SAMPLE, SETTLE, STROBE, WAIT, DONE} state_t;

    // With no settle time a bit update goes straight to the comparator strobe.
    localparam state_t AFTER_BIT = (SETTLE_CYCLES == 0) ? STROBE : SETTLE;

    state_t        state, state_nxt;
    logic [7:0]    cnt;
    logic [KW-1:0] k, k_nxt;
    logic [N-1:0]  cap_nxt, dout_nxt;
    logic          busy_nxt, samp_nxt, comp_clk_nxt, dout_valid_nxt;

    wire sample_last = (cnt == 8'(SAMPLE_CYCLES - 1));
    wire settle_last = (cnt == 8'(SETTLE_CYCLES - 1));

    assign cap_botplate_d = ~cap_botplate_m;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            k              <= '0;
            busy           <= 1'b0;
            samp           <= 1'b0;
            comp_clk       <= 1'b0;
            cap_botplate_m <= '0;
            dout           <= '0;
            dout_valid     <= 1'b0;
        end else begin
            state          <= state_nxt;
            cnt            <= (state_nxt != state) ? 8'd0 : cnt + 8'd1;
            k              <= k_nxt;
            busy           <= busy_nxt;
            samp           <= samp_nxt;
            comp_clk       <= comp_clk_nxt;
            cap_botplate_m <= cap_nxt;
            dout           <= dout_nxt;
            dout_valid     <= dout_valid_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SAMPLE;
            SAMPLE:  if (sample_last) state_nxt = AFTER_BIT;
            SETTLE:  if (settle_last) state_nxt = STROBE;
            STROBE:  state_nxt = WAIT;
            WAIT:    if (comp_valid) state_nxt = (k == '0) ? DONE : AFTER_BIT;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are computed from the next state so the registered copy lines up with it.
    always_comb begin
        busy_nxt       = (state_nxt != IDLE);
        samp_nxt       = (state_nxt == SAMPLE);
        comp_clk_nxt   = (state_nxt == STROBE);
        cap_nxt        = cap_botplate_m;
        k_nxt          = k;
        dout_nxt       = dout;
        dout_valid_nxt = dout_valid & ~dout_ready;
        case (state)
            SAMPLE: if (state_nxt != SAMPLE) begin
                cap_nxt        = '0;
                cap_nxt[N-1]   = 1'b1;
                k_nxt          = KW'(N - 1);
            end
            WAIT: if (comp_valid) begin
                if (!comp_out) cap_nxt[k] = 1'b0;
                if (k != '0) begin
                    cap_nxt[k - KW'(1)] = 1'b1;
                    k_nxt               = k - KW'(1);
                end
            end
            DONE: begin
                dout_nxt       = cap_botplate_m;
                dout_valid_nxt = 1'b1;
                cap_nxt        = '0;
            end
            default: ;
        endcase
    end

`ifdef SAR_OVERRUN_EN
    always_ff @(posedge clk) begin
        if (rst)
            overrun <= 1'b0;
        else if (state == DONE && dout_valid && !dout_ready)
            overrun <= 1'b1;
    end
`endif

endmodule

// File: doc/sar_logic.md
Name: sar_logic

Overview:
- Successive-approximation controller that drives the bottom plates of the capacitive DAC array and consumes the comparator decision.
- It sequences sample, bit-trial and settle phases, and commits one trial bit per comparator decision, MSB first.
- It presents the N-bit conversion result on a valid/ready output port.
- It sits between the caparray/comparator analog macros and the digital readout path.

Parameters:
N, 16, resolution; width of cap_botplate_m, cap_botplate_d and dout
SAMPLE_CYCLES, 4, clk cycles samp is held high (legal range 1..255)
SETTLE_CYCLES, 1, clk cycles between a bottom-plate update and the comp_clk pulse (legal range 0..15)

Ports:
clk  input  1  single clock; all logic is rising-edge
rst  input  1  synchronous reset, active-high
start  input  1  conversion request pulse; accepted only in IDLE
busy  output  1  high from the accepted start until the result is written
samp  output  1  sampling switch enable for the top plate
cap_botplate_m  output  N  main bottom-plate drive, bit N-1 = MSB cap
cap_botplate_d  output  N  diff bottom-plate drive, always the bitwise complement of cap_botplate_m
comp_clk  output  1  one-cycle comparator strobe
comp_valid  input  1  comparator decision valid (may arrive 1..k cycles after comp_clk)
comp_out  input  1  comparator decision; 1 = keep the trial bit
dout  output  N  conversion result
dout_valid  output  1  result available
dout_ready  input  1  downstream accepts the result

Behaviour:
- Reset (rst=1 at a clk edge) returns the FSM to IDLE from any state, including mid-conversion. It forces: busy=0, samp=0, cap_botplate_m=0, cap_botplate_d=all ones, comp_clk=0, dout=0, dout_valid=0. The bit index and counters are cleared.
- The FSM states are IDLE, SAMPLE, SETTLE, STROBE, WAIT, DONE. All outputs are registered.
- IDLE:
  - start=1 moves to SAMPLE on the next edge; busy=1 and samp=1 take effect in that cycle.
  - start is ignored in every other state, with no queuing.
- SAMPLE:
  - Hold for exactly SAMPLE_CYCLES cycles with cap_botplate_m=0.
  - On exit: samp=0, cap_botplate_m = (1<<(N-1)) (MSB trial), bit index k=N-1, then go to SETTLE.
- SETTLE:
  - Hold for SETTLE_CYCLES cycles.
  - If SETTLE_CYCLES=0, go directly to STROBE.
- STROBE:
  - comp_clk=1 for exactly one cycle, then go to WAIT.
- WAIT:
  - Hold until comp_valid=1.
  - comp_valid during STROBE or SETTLE is ignored.
  - On comp_valid: if comp_out=0, clear bit k; otherwise keep bit k.
  - If k>0: set bit k-1, decrement k, go to SETTLE.
  - If k=0: go to DONE.
  - The clear of bit k and the set of bit k-1 land in the same register update.
- DONE (one cycle):
  - dout = cap_botplate_m, dout_valid=1, busy=0.
  - cap_botplate_m returns to 0 and cap_botplate_d to all ones.
  - Go to IDLE.
- cap_botplate_d == ~cap_botplate_m every cycle, including during reset.
- Output handshake:
  - dout_valid&dout_ready at a clk edge clears dout_valid.
  - dout is held stable while dout_valid=1, unless a new DONE overwrites it.
  - A DONE coinciding with a handshake leaves dout_valid=1 with the new data.
- Latency, with comp_valid returned one cycle after comp_clk: the start edge to DONE is SAMPLE_CYCLES + N*(SETTLE_CYCLES+2) cycles. dout_valid rises on the following edge.
- A start in the same cycle as DONE is ignored, because the FSM is not yet in IDLE.

Optional Feature:
- Macro SAR_OVERRUN_EN.
- When defined:
  - Adds output port overrun (1 bit, reset 0).
  - overrun is set sticky when DONE writes dout while dout_valid=1 and dout_ready=0, i.e. an unread result was overwritten.
  - It is cleared only by rst.
- When undefined:
  - The port and logic are absent.
  - Overwrite is silent; all other behaviour is identical.

Test Plan:
- N=8, SETTLE_CYCLES=1; comparator model keeps bit k iff code 0xA5 has bit k set, comp_valid one cycle after comp_clk; pulse start -> dout=0xA5, dout_valid high exactly 4+8*3+1 cycles after the start edge, busy low, cap_botplate_m=0x00 and cap_botplate_d=0xFF afterwards.
- Trial sequence check with comp_out stuck 1 -> cap_botplate_m steps 0x80,0xC0,0xE0,...,0xFF; dout=0xFF. With comp_out stuck 0 -> steps 0x80,0x40,...,0x01; dout=0x00.
- comp_valid delayed 5 cycles per decision, plus a spurious comp_valid during SETTLE -> spurious pulse ignored, result unchanged (0xA5), comp_clk pulses exactly 8 times each 1 cycle wide.
- Assert rst after bit 4 is decided -> the next edge shows busy=0, samp=0, cap_botplate_m=0, dout_valid=0. A fresh start then converts correctly to 0xA5.
- start pulses while busy -> ignored, only one conversion occurs. Hold dout_ready=0 across two conversions (0x3C then 0xC3) -> dout=0xC3, dout_valid=1, overrun=1 (SAR_OVERRUN_EN). Then dout_ready=1 -> dout_valid falls next edge; overrun stays 1 until rst.
